// File: rtl/zero_count_seq_pkg.sv
// ---------------------------------------------------------------------------
// zcs_pkg : shared types and width helpers for the zero_count_seq slice.
//   zcs_state_e : sequencer states (IDLE / RUN / DONE)
//   zcs_cnt_w() : bits needed to hold a count in the range 0..bits
// ---------------------------------------------------------------------------
package zcs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } zcs_state_e;

    // Width of a counter that must represent every value from 0 to bits inclusive.
    function automatic int zcs_cnt_w(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/zero_count_seq_if.sv
// ---------------------------------------------------------------------------
// zero_count_seq_if : word-in / count-out handshake bundle.
//   in_valid, in_ready, in_data : word producer side (valid/ready)
//   out_valid, out_ready, out_count : count consumer side (valid/ready)
//   busy : sequencer is working on or holding a word
// Modports: master (producer/consumer environment), slave (the sequencer).
// ---------------------------------------------------------------------------
interface zero_count_seq_if
    import zcs_pkg::*;
#(
    parameter int WORD_W = 32
) ();

    localparam int CNT_W = zcs_cnt_w(WORD_W);

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count, busy
    );

endinterface

// File: rtl/zero_count_seq_zero_counter.sv
// ---------------------------------------------------------------------------
// zero_counter : combinational count of zero bits in an IN_W-bit chunk.
//   din   in  IN_W              chunk to inspect
//   count out zcs_cnt_w(IN_W)   number of bits of din that are 0
// ---------------------------------------------------------------------------
module zero_counter
    import zcs_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0]            din,
    output logic [zcs_cnt_w(IN_W)-1:0] count
);

    localparam int CHK_W = zcs_cnt_w(IN_W);

    logic [CHK_W-1:0] count_s;

    // Population count of the inverted chunk.
    always_comb begin
        count_s = {CHK_W{1'b0}};
        for (int i = 0; i < IN_W; i++) begin
            count_s = count_s + CHK_W'(~din[i]);
        end
    end

    assign count = count_s;

endmodule

// File: rtl/zero_count_seq.sv
// ---------------------------------------------------------------------------
// zero_count_seq : counts the zero bits of a WORD_W-bit word by feeding one
// IN_W-bit chunk per cycle (LSB chunk first) through a single zero_counter.
// One word in flight; result held on out_count until the consumer takes it.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    zero_count_seq_if.slave : in_valid/in_ready/in_data,
//          out_valid/out_ready/out_count, busy
// Optional build macro ZCS_EARLY_EXIT_EN: leave RUN as soon as the remaining
// shift register is all ones (no zeros left); the count is unchanged, only
// latency shortens. Without it RUN always lasts exactly NCHUNK cycles.
// ---------------------------------------------------------------------------
module zero_count_seq
    import zcs_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int IN_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    zero_count_seq_if.slave       bus
);

    localparam int NCHUNK = WORD_W / IN_W;
    localparam int CNT_W  = zcs_cnt_w(WORD_W);
    localparam int CHK_W  = zcs_cnt_w(IN_W);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if ((WORD_W % IN_W) != 0) begin : g_width_check
            $error("zero_count_seq: WORD_W must be a multiple of IN_W");
        end
    endgenerate

    // Top IN_W bits set: the fill pattern shifted in behind consumed chunks.
    localparam logic [WORD_W-1:0] FILL_MASK = ~({WORD_W{1'b1}} >> IN_W);

    zcs_state_e        state_r;
    zcs_state_e        state_s;
    logic [WORD_W-1:0] shreg_r;
    logic [CNT_W-1:0]  acc_r;
    logic [IDX_W-1:0]  idx_r;
    logic [CNT_W-1:0]  out_count_r;
    logic              out_valid_r;
    logic              in_ready_r;
    logic              busy_r;

    logic [CHK_W-1:0]  chunk_cnt_s;
    logic [CNT_W-1:0]  acc_sum_s;
    logic [WORD_W-1:0] shreg_shift_s;
    logic              accept_s;
    logic              last_s;

    zero_counter #(
        .IN_W (IN_W)
    ) u_zero_counter (
        .din   (shreg_r[IN_W-1:0]),
        .count (chunk_cnt_s)
    );

    assign acc_sum_s     = acc_r + CNT_W'(chunk_cnt_s);
    assign shreg_shift_s = (shreg_r >> IN_W) | FILL_MASK;
    assign accept_s      = bus.in_valid && in_ready_r;
    assign last_s        = (idx_r == IDX_W'(NCHUNK - 1));

`ifdef ZCS_EARLY_EXIT_EN
    logic all_ones_s;
    // Consumed chunks are refilled with ones, so all-ones means no zeros remain.
    assign all_ones_s = &shreg_r;
`endif

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
`ifdef ZCS_EARLY_EXIT_EN
                if (all_ones_s || last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
`else
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
`endif
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and handshake outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    // Datapath: load on accept, consume one chunk per RUN cycle, latch the total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r     <= {WORD_W{1'b1}};
            acc_r       <= {CNT_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            out_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shreg_r <= bus.in_data;
                        acc_r   <= {CNT_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                    end
                end
                ST_RUN: begin
`ifdef ZCS_EARLY_EXIT_EN
                    if (all_ones_s) begin
                        // Remaining chunks contribute nothing; acc is already final.
                        out_count_r <= acc_r;
                    end else begin
                        acc_r   <= acc_sum_s;
                        shreg_r <= shreg_shift_s;
                        idx_r   <= idx_r + IDX_W'(1);
                        if (last_s) begin
                            out_count_r <= acc_sum_s;
                        end
                    end
`else
                    acc_r   <= acc_sum_s;
                    shreg_r <= shreg_shift_s;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        out_count_r <= acc_sum_s;
                    end
`endif
                end
                ST_DONE: begin
                    // Result held on out_count_r until (and after) the handshake.
                end
                default: begin
                    shreg_r <= {WORD_W{1'b1}};
                    acc_r   <= {CNT_W{1'b0}};
                    idx_r   <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_count = out_count_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_zero_count_seq.sv
module tb_zero_count_seq;

    localparam int WORD_W = 32;
    localparam int IN_W   = 8;

`ifdef ZCS_EARLY_EXIT_EN
    localparam int LAT_FF00     = 2;
    localparam int LAT_FFFF     = 1;
    localparam int LAT_FFFF0000 = 3;
`else
    localparam int LAT_FF00     = 4;
    localparam int LAT_FFFF     = 4;
    localparam int LAT_FFFF0000 = 4;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   lat;

    zero_count_seq_if #(.WORD_W(WORD_W)) bus ();

    zero_count_seq #(
        .WORD_W (WORD_W),
        .IN_W   (IN_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Offer one word (called at a negedge), return cycles from accept edge to out_valid.
    task automatic send_and_wait(input logic [31:0] data, output int n);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hDEAD_BEEF;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    // Complete the output handshake (called at a negedge).
    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0000_0000;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All zeros
        send_and_wait(32'h0000_0000, lat);
        check("zero_lat", 32'(lat), 32'd4);
        check("zero_count", 32'(bus.out_count), 32'd32);
        check("zero_busy", 32'(bus.busy), 32'd1);
        check("zero_in_ready", 32'(bus.in_ready), 32'd0);
        take_result();
        check("zero_post_valid", 32'(bus.out_valid), 32'd0);
        check("zero_post_ready", 32'(bus.in_ready), 32'd1);
        check("zero_post_busy", 32'(bus.busy), 32'd0);
        check("zero_post_count_held", 32'(bus.out_count), 32'd32);

        // Mixed chunks 5,8,4,4
        send_and_wait(32'hF0F0_0007, lat);
        check("mix_lat", 32'(lat), 32'd4);
        check("mix_count", 32'(bus.out_count), 32'd21);
        take_result();

        // Only low chunk has zeros
        send_and_wait(32'hFFFF_FF00, lat);
        check("ff00_lat", 32'(lat), 32'(LAT_FF00));
        check("ff00_count", 32'(bus.out_count), 32'd8);
        take_result();

        // No zeros at all
        send_and_wait(32'hFFFF_FFFF, lat);
        check("ffff_lat", 32'(lat), 32'(LAT_FFFF));
        check("ffff_count", 32'(bus.out_count), 32'd0);
        take_result();

        // Backpressure: result held, a concurrent offer of 0x0 is refused
        send_and_wait(32'hF0F0_0007, lat);
        check("bp_lat", 32'(lat), 32'd4);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_count", 32'(bus.out_count), 32'd21);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        take_result();
        check("bp_post_valid", 32'(bus.out_valid), 32'd0);
        check("bp_post_busy", 32'(bus.busy), 32'd0);
        check("bp_post_count", 32'(bus.out_count), 32'd21);

        // Reset two cycles into RUN
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_out_count", 32'(bus.out_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_idle_ready", 32'(bus.in_ready), 32'd1);
        send_and_wait(32'h00FF_00FF, lat);
        check("mrst_word_lat", 32'(lat), 32'd4);
        check("mrst_word_count", 32'(bus.out_count), 32'd16);
        take_result();

        // Back-to-back with in_valid and out_ready held high
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_0000;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_data = 32'hFFFF_0000;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("b2b_first_lat", 32'(lat), 32'd4);
        check("b2b_first_count", 32'(bus.out_count), 32'd32);
        @(posedge clk);
        @(negedge clk);
        check("b2b_gap_valid", 32'(bus.out_valid), 32'd0);
        check("b2b_gap_ready", 32'(bus.in_ready), 32'd1);
        check("b2b_gap_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_accept_ready", 32'(bus.in_ready), 32'd0);
        check("b2b_accept_busy", 32'(bus.busy), 32'd1);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("b2b_second_lat", 32'(lat), 32'(LAT_FFFF0000));
        check("b2b_second_count", 32'(bus.out_count), 32'd16);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("b2b_end_valid", 32'(bus.out_valid), 32'd0);
        check("b2b_end_ready", 32'(bus.in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
